// File: rtl/bid_master.sv
// rtl/bid_master.sv - bidding master agent for one bmif port: command FIFO, bid FSM, balance mirror
// Optional feature macro: BID_ESCALATE_EN (raise the bid while waiting for a grant).
module bid_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REQ_W      = 4,
    parameter int INIT_BAL   = 900,
    parameter int ESC_CYC    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] rst_balance,
    input  logic signed [31:0] rst_clock,
    input  logic signed [31:0] max_balance,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic               cmd_rw,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic [REQ_W-1:0]   cmd_bid,
    output logic [REQ_W-1:0]   req,
    input  logic               grant,
    output logic [ADDR_W-1:0]  addr,
    output logic               RW,
    output logic [DATA_W-1:0]  DataToSlave,
    input  logic [DATA_W-1:0]  DataFromSlave,
    output logic               rsp_valid,
    output logic               rsp_rw,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic signed [31:0] balance,
    output logic [15:0]        grant_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, BID} state_t;
    state_t state, state_d;

    logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
    logic              mem_rw    [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_wdata [FIFO_DEPTH];
    logic [REQ_W-1:0]  mem_bid   [FIFO_DEPTH];

    logic [PW:0]        wr_ptr, rd_ptr, count;
    logic [PW-1:0]      head, load_idx;
    logic               push, pop, load;
    logic [REQ_W-1:0]   bid_reg, raw_bid, load_bid;
    logic signed [31:0] repl_cnt, bal_sum, bal_diff, bal_cap;
    logic               repl_hit;

    assign count     = wr_ptr - rd_ptr;
    assign cmd_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = rd_ptr[PW-1:0];
    assign req       = (state == BID) ? bid_reg : '0;

    // bal_cap = max(1, balance-1): the highest bid the arbiter will still honour
    assign bal_cap  = (balance > 32'sd1) ? (balance - 32'sd1) : 32'sd1;
    assign bal_sum  = balance + rst_balance;
    assign bal_diff = balance - $signed({{(32-REQ_W){1'b0}}, bid_reg});
    assign repl_hit = (repl_cnt == rst_clock);

    always_comb begin
        state_d  = state;
        load     = 1'b0;
        pop      = 1'b0;
        load_idx = head;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load    = 1'b1;
                    state_d = BID;
                end
            end
            BID: begin
                if (grant) begin
                    pop = 1'b1;
                    if (count > (PW+1)'(1)) begin
                        load     = 1'b1;
                        load_idx = head + PW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        raw_bid  = mem_bid[load_idx];
        load_bid = (raw_bid == '0) ? REQ_W'(1) : raw_bid;
        if ($signed({{(32-REQ_W){1'b0}}, load_bid}) >= balance)
            load_bid = REQ_W'(bal_cap);
    end

`ifdef BID_ESCALATE_EN
    localparam int ESC_W   = $clog2(ESC_CYC) + 1;
    localparam int REQ_MAX = (1 << REQ_W) - 1;
    logic [ESC_W-1:0] esc_cnt;
    logic [REQ_W-1:0] esc_cap;
    assign esc_cap = (bal_cap >= REQ_MAX) ? '1 : REQ_W'(bal_cap);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[PW-1:0]]  <= cmd_addr;
            mem_rw[wr_ptr[PW-1:0]]    <= cmd_rw;
            mem_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
            mem_bid[wr_ptr[PW-1:0]]   <= cmd_bid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            addr        <= '0;
            RW          <= 1'b0;
            DataToSlave <= '0;
            bid_reg     <= '0;
            rsp_valid   <= 1'b0;
            rsp_rw      <= 1'b0;
            rsp_rdata   <= '0;
            grant_cnt   <= '0;
            balance     <= INIT_BAL;
            repl_cnt    <= '0;
`ifdef BID_ESCALATE_EN
            esc_cnt     <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rsp_valid <= pop;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                grant_cnt <= grant_cnt + 16'd1;
                rsp_rw    <= RW;
                rsp_rdata <= RW ? '0 : DataFromSlave;
            end
            if (load) begin
                addr        <= mem_addr[load_idx];
                RW          <= mem_rw[load_idx];
                DataToSlave <= mem_wdata[load_idx];
                bid_reg     <= load_bid;
            end
`ifdef BID_ESCALATE_EN
            if (pop || load) begin
                esc_cnt <= '0;
            end else if (state == BID) begin
                if (esc_cnt == ESC_W'(ESC_CYC - 1)) begin
                    esc_cnt <= '0;
                    if (bid_reg < esc_cap) bid_reg <= bid_reg + 1'b1;
                end else begin
                    esc_cnt <= esc_cnt + 1'b1;
                end
            end
`endif
            // a grant landing on the replenish cycle is never charged, matching the arbiter
            if (repl_hit) begin
                repl_cnt <= '0;
                balance  <= (bal_sum > max_balance) ? max_balance : bal_sum;
            end else begin
                repl_cnt <= repl_cnt + 32'sd1;
                if (pop) balance <= (bal_diff < 32'sd1) ? 32'sd1 : bal_diff;
            end
        end
    end
endmodule

// File: tb/tb_bid_master.sv
// tb/tb_bid_master.sv - directed self-checking bench for bid_master
module tb_bid_master;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] rst_balance, rst_clock, max_balance;
    logic               cmd_valid, cmd_ready, cmd_rw;
    logic [31:0]        cmd_addr, cmd_wdata;
    logic [3:0]         cmd_bid, req;
    logic               grant, grant_auto, grant_force;
    logic [31:0]        addr, DataToSlave, DataFromSlave, rsp_rdata;
    logic               RW, rsp_valid, rsp_rw;
    logic signed [31:0] balance;
    logic [15:0]        grant_cnt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    assign grant = grant_auto ? (req != 4'd0) : grant_force;

    bid_master dut (
        .clk(clk), .rst(rst), .rst_balance(rst_balance), .rst_clock(rst_clock),
        .max_balance(max_balance), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .cmd_bid(cmd_bid),
        .req(req), .grant(grant), .addr(addr), .RW(RW), .DataToSlave(DataToSlave),
        .DataFromSlave(DataFromSlave), .rsp_valid(rsp_valid), .rsp_rw(rsp_rw),
        .rsp_rdata(rsp_rdata), .balance(balance), .grant_cnt(grant_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = w;
        cmd_wdata = d;
        cmd_bid   = b;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0; cmd_bid = '0;
        grant_auto = 1'b0; grant_force = 1'b0; DataFromSlave = '0;
        rst_balance = 50; rst_clock = 1000000; max_balance = 920;
        tick();
        tick();
        chk("rst_req", {28'd0, req}, 32'd0);
        chk("rst_balance", balance, 32'd900);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_grant_cnt", {16'd0, grant_cnt}, 32'd0);
        rst = 1'b0;

        // reset in the middle of a BID
        set_cmd(32'hFFEF_0100, 1'b0, 32'd0, 4'd5);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t1_req_bid", {28'd0, req}, 32'd5);
        rst = 1'b1;
        tick();
        chk("t1_req", {28'd0, req}, 32'd0);
        chk("t1_balance", balance, 32'd900);
        chk("t1_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t1_flushed", {28'd0, req}, 32'd0);

        // single write with grant tied to req
        grant_auto = 1'b1;
        DataFromSlave = 32'hDEAD_BEEF;
        set_cmd(32'hFFEF_1200, 1'b1, 32'h1234_5678, 4'd6);
        tick();
        cmd_valid = 1'b0;
        chk("t2_req_n1", {28'd0, req}, 32'd0);
        tick();
        chk("t2_req", {28'd0, req}, 32'd6);
        chk("t2_addr", addr, 32'hFFEF_1200);
        chk("t2_rw", {31'd0, RW}, 32'd1);
        chk("t2_wdata", DataToSlave, 32'h1234_5678);
        chk("t2_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rdata", rsp_rdata, 32'd0);
        chk("t2_rsp_rw", {31'd0, rsp_rw}, 32'd1);
        chk("t2_balance", balance, 32'd894);
        chk("t2_grant_cnt", {16'd0, grant_cnt}, 32'd1);
        tick();
        chk("t2_pulse", {31'd0, rsp_valid}, 32'd0);
        grant_auto = 1'b0;

        // three back-to-back reads
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_cmd(32'hFFEF_0200 + 32'(i * 4), 1'b0, 32'd0, 4'd2);
            tick();
        end
        cmd_valid = 1'b0;
        chk("t3_req", {28'd0, req}, 32'd2);
        grant_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DataFromSlave = 32'hA5A5_0000 + 32'(i);
            tick();
            chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_rdata", rsp_rdata, 32'hA5A5_0000 + 32'(i));
        end
        grant_force = 1'b0;
        chk("t3_grant_cnt", {16'd0, grant_cnt}, 32'd3);
        chk("t3_balance", balance, 32'd894);
        tick();
        chk("t3_idle_req", {28'd0, req}, 32'd0);
        chk("t3_pulse_end", {31'd0, rsp_valid}, 32'd0);

        // clamp: pull balance down to 4 through the max_balance ceiling
        rst_clock = 2; rst_balance = 0; max_balance = 4;
        do_reset();
        tick();
        tick();
        tick();
        chk("t4_balance4", balance, 32'd4);
        rst_clock = 1000000;
        grant_auto = 1'b1;
        set_cmd(32'hFFEF_0300, 1'b0, 32'd0, 4'd15);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t4_req_clamp", {28'd0, req}, 32'd3);
        tick();
        chk("t4_balance1", balance, 32'd1);
        set_cmd(32'hFFEF_0304, 1'b0, 32'd0, 4'd15);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t4_req_min", {28'd0, req}, 32'd1);
        tick();
        chk("t4_balance_floor", balance, 32'd1);
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        grant_auto = 1'b0;

        // replenish with a grant on the replenish cycle
        rst_clock = 9; rst_balance = 50; max_balance = 920;
        do_reset();
        set_cmd(32'hFFEF_0400, 1'b0, 32'd0, 4'd6);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t5_req", {28'd0, req}, 32'd6);
        repeat (7) tick();
        chk("t5_pre_repl", balance, 32'd900);
        grant_force = 1'b1;
        DataFromSlave = 32'h0000_5A5A;
        tick();
        grant_force = 1'b0;
        chk("t5_balance_repl", balance, 32'd920);
        chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        set_cmd(32'hFFEF_0404, 1'b0, 32'd0, 4'd6);
        tick();
        cmd_valid = 1'b0;
        tick();
        grant_force = 1'b1;
        tick();
        grant_force = 1'b0;
        chk("t5_balance_charge", balance, 32'd914);

        // full FIFO, grant held low, optional escalation
        rst_clock = 1000000;
        do_reset();
        set_cmd(32'hFFEF_0500, 1'b0, 32'd0, 4'd3);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_full", {31'd0, cmd_ready}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("t6_still_full", {31'd0, cmd_ready}, 32'd0);
        chk("t6_req", {28'd0, req}, 32'd3);
        repeat (5) tick();
`ifdef BID_ESCALATE_EN
        chk("t6_req_8", {28'd0, req}, 32'd4);
`else
        chk("t6_req_8", {28'd0, req}, 32'd3);
`endif
        repeat (8) tick();
`ifdef BID_ESCALATE_EN
        chk("t6_req_16", {28'd0, req}, 32'd5);
`else
        chk("t6_req_16", {28'd0, req}, 32'd3);
`endif
        grant_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_drain", {31'd0, rsp_valid}, 32'd1);
        end
        grant_force = 1'b0;
        chk("t6_grant_cnt", {16'd0, grant_cnt}, 32'd4);
        tick();
        chk("t6_empty_req", {28'd0, req}, 32'd0);
        chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
